// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and drives datapath selects and enables.
module multicycle_ctrl_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ALU_op,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [3:0] S_START    = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMREAD  = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_MEMWB    = 4'd6;
  localparam logic [3:0] S_EXECR    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_ILLEGAL  = 4'd12;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [3:0] state;
  logic [3:0] next_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_START;
    else          state <= next_state;
  end

  always_comb begin
    next_state = S_START;
    case (state)
      S_START:    next_state = S_FETCH;
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          default:      next_state = S_ILLEGAL;
        endcase
      end
      // lw and sw differ only in opcode bit 5
      S_MEMADR:   next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      S_MEMWB:    next_state = S_FETCH;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BEQ:      next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      S_ILLEGAL:  next_state = S_ILLEGAL;
      default:    next_state = S_START;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    ALU_op     = 2'b00;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        ALU_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        ALU_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        ALU_op     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: walks each instruction class, the
// mem_ready stall paths, the illegal-opcode halt and asynchronous reset.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       pc_write, branch, adr_src, mem_write, ir_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, ALU_op;
  logic       reg_write, instr_done, illegal;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl_fsm dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .branch     (branch),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ALU_op     (ALU_op),
    .reg_write  (reg_write),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Packed order: pcw br adr mw irw rs[2] sa[2] sb[2] op[2] rw done ill
  logic [15:0] obs;
  assign obs = {pc_write, branch, adr_src, mem_write, ir_write, result_src,
                alu_src_a, alu_src_b, ALU_op, reg_write, instr_done, illegal};

  function automatic logic [15:0] mk(logic pcw, logic br, logic adr, logic mw,
      logic irw, logic [1:0] rs, logic [1:0] sa, logic [1:0] sb, logic [1:0] op,
      logic rw, logic done, logic ill);
    return {pcw, br, adr, mw, irw, rs, sa, sb, op, rw, done, ill};
  endfunction

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic [15:0] e_start, e_fetch_rdy, e_fetch_wait, e_decode, e_memadr, e_memread,
               e_memwr_wait, e_memwr_rdy, e_memwb, e_execr, e_execi, e_aluwb,
               e_beq, e_jal, e_illegal;

  task automatic chk(input string tag, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    e_start      = mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0);
    e_fetch_rdy  = mk(1,0,0,0,1,2'b10,2'b00,2'b10,2'b00,0,0,0);
    e_fetch_wait = mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0,0);
    e_decode     = mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,0);
    e_memadr     = mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,0);
    e_memread    = mk(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0);
    e_memwr_wait = mk(0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,0,0,0);
    e_memwr_rdy  = mk(0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,0,1,0);
    e_memwb      = mk(0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,1,0);
    e_execr      = mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0,0);
    e_execi      = mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,0,0,0);
    e_aluwb      = mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,1,0);
    e_beq        = mk(0,1,0,0,0,2'b00,2'b10,2'b00,2'b01,0,1,0);
    e_jal        = mk(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,0,0,0);
    e_illegal    = mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,1);

    reset_n   = 1'b0;
    mem_ready = 1'b1;
    opcode    = OP_R;
    step(); chk("reset_start", e_start);
    step(); chk("reset_hold", e_start);

    // R-type: START, FETCH, DECODE, EXECR, ALUWB, FETCH at cycle 5
    @(negedge clk); reset_n = 1'b1;
    #1; chk("r_c0_start", e_start);
    step(); chk("r_c1_fetch", e_fetch_rdy);
    step(); chk("r_c2_decode", e_decode);
    step(); chk("r_c3_execr", e_execr);
    step(); chk("r_c4_aluwb", e_aluwb);
    step(); chk("r_c5_fetch", e_fetch_rdy);

    // lw: 2 wait cycles in FETCH, 3 in MEMREAD
    mem_ready = 1'b0; opcode = OP_LW;
    #1; chk("lw_fetch_w1", e_fetch_wait);
    step(); chk("lw_fetch_w2", e_fetch_wait);
    mem_ready = 1'b1;
    #1; chk("lw_fetch_rdy", e_fetch_rdy);
    step(); chk("lw_decode", e_decode);
    mem_ready = 1'b0;
    #1; chk("lw_decode_ign_rdy", e_decode);
    step(); chk("lw_memadr", e_memadr);
    step(); chk("lw_memread_w1", e_memread);
    step(); chk("lw_memread_w2", e_memread);
    step(); chk("lw_memread_w3", e_memread);
    mem_ready = 1'b1;
    #1; chk("lw_memread_rdy", e_memread);
    step(); chk("lw_memwb", e_memwb);
    step(); chk("lw_fetch_next", e_fetch_rdy);

    // sw: one wait cycle in MEMWRITE
    opcode = OP_SW;
    step(); chk("sw_decode", e_decode);
    step(); chk("sw_memadr", e_memadr);
    mem_ready = 1'b0;
    step(); chk("sw_memwr_w1", e_memwr_wait);
    mem_ready = 1'b1;
    #1; chk("sw_memwr_rdy", e_memwr_rdy);
    step(); chk("sw_fetch_next", e_fetch_rdy);

    opcode = OP_BEQ;
    step(); chk("beq_decode", e_decode);
    step(); chk("beq_exec", e_beq);
    step(); chk("beq_fetch_next", e_fetch_rdy);

    opcode = OP_JAL;
    step(); chk("jal_decode", e_decode);
    step(); chk("jal_state", e_jal);
    step(); chk("jal_aluwb", e_aluwb);
    step(); chk("jal_fetch_next", e_fetch_rdy);

    opcode = OP_I;
    step(); chk("i_decode", e_decode);
    step(); chk("i_execi", e_execi);
    step(); chk("i_aluwb", e_aluwb);
    step(); chk("i_fetch_next", e_fetch_rdy);

    // Unsupported opcode halts until reset
    opcode = OP_LUI;
    step(); chk("ill_decode", e_decode);
    for (int i = 0; i < 20; i++) begin
      step();
      mem_ready = i[0];
      opcode    = OP_R;
      chk($sformatf("ill_hold_%0d", i), e_illegal);
    end
    #2 reset_n = 1'b0;
    #1; chk("ill_async_reset", e_start);
    @(negedge clk); reset_n = 1'b1; mem_ready = 1'b1; opcode = OP_SW;
    #1; chk("ill_after_reset", e_start);
    step(); chk("ill_refetch", e_fetch_rdy);

    // Reset during MEMWRITE drops mem_write before any clock edge
    step(); chk("rst_sw_decode", e_decode);
    step(); chk("rst_sw_memadr", e_memadr);
    mem_ready = 1'b0;
    step(); chk("rst_sw_memwr", e_memwr_wait);
    #2 reset_n = 1'b0;
    #1; chk("rst_sw_async_drop", e_start);
    step(); chk("rst_sw_hold_start", e_start);
    @(negedge clk); reset_n = 1'b1; mem_ready = 1'b1;
    #1; chk("rst_sw_start", e_start);
    step(); chk("rst_sw_fetch", e_fetch_rdy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
